// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared widths, 640x400 timing constants and arbiter FSM codes.
// Revision    : 1.0
// ============================================================================
package vga_pkg;

    localparam int c_ADDR_W    = 15;
    localparam int c_DATA_W    = 8;
    localparam int c_FRAME_W   = 16;

    localparam int c_H_ACTIVE  = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_H_TOTAL   = c_H_ACTIVE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_V_ACTIVE  = 400;
    localparam int c_V_FRONT   = 12;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 35;
    localparam int c_V_TOTAL   = c_V_ACTIVE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    localparam logic [1:0] c_S_HOLD  = 2'd0;
    localparam logic [1:0] c_S_DRAIN = 2'd1;
    localparam logic [1:0] c_S_IDLE  = 2'd2;

    function automatic logic [c_FRAME_W-1:0] sat_add1(
        input logic [c_FRAME_W-1:0] v,
        input logic                 inc
    );
        logic [c_FRAME_W-1:0] r;
        r = v;
        if (inc && (v != '1)) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vram_wr_fifo
// Description : Synchronous FIFO holding {addr,data} write entries.
// Revision    : 1.0
// ============================================================================
module vram_wr_fifo #(
    parameter  int WIDTH = 23,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares a single-port VRAM: display reads always win, buffered
//               game writes drain into free (optionally blanking-only) cycles.
// Revision    : 1.0
// ============================================================================
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_blanking,
    input  logic                 i_animate,
    input  logic                 i_disp_req,
    input  logic [ADDR_W-1:0]    i_disp_addr,
    output logic                 o_disp_valid,
    output logic [DATA_W-1:0]    o_disp_data,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [DATA_W-1:0]    i_wr_data,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic                 o_mem_we,
    output logic [DATA_W-1:0]    o_mem_wdata,
    input  logic [DATA_W-1:0]    i_mem_rdata,
    output logic                 o_pending,
    output logic [c_FRAME_W-1:0] o_frame_writes
);

    localparam int c_ENTRY_W = ADDR_W + DATA_W;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic                 w_drain_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_fifo_next_empty;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic [c_ENTRY_W-1:0] w_head;

    logic [1:0]           r_state;
    logic                 r_disp_valid;
    logic [c_FRAME_W-1:0] r_write_count;
    logic [c_FRAME_W-1:0] r_frame_writes;

    generate
        if (BLANK_ONLY) begin : g_blank_drain
            assign w_drain_ok = i_blanking;
        end else begin : g_any_drain
            assign w_drain_ok = 1'b1;
        end
    endgenerate

    // Ready looks only at the registered fill level, so a full FIFO refuses
    // a push even in the cycle it pops.
    assign o_wr_ready = !w_fifo_full && !i_rst;
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = !i_rst && !i_disp_req && w_drain_ok && !w_fifo_empty;

    vram_wr_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data ({i_wr_addr, i_wr_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign o_mem_we       = w_pop;
    assign o_mem_addr     = w_pop ? w_head[c_ENTRY_W-1:DATA_W] : i_disp_addr;
    assign o_mem_wdata    = w_head[DATA_W-1:0];
    assign o_disp_data    = i_mem_rdata;
    assign o_disp_valid   = r_disp_valid;
    assign o_pending      = !w_fifo_empty;
    assign o_frame_writes = r_frame_writes;

    assign w_fifo_next_empty = w_fifo_empty
                             ? !w_push
                             : ((w_fifo_count == c_CNT_W'(1)) && w_pop && !w_push);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= i_disp_req;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_S_HOLD;
        end else begin
            case (r_state)
                c_S_HOLD: begin
                    if (w_drain_ok) begin
                        r_state <= w_fifo_empty ? c_S_IDLE : c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    if (!w_drain_ok) begin
                        r_state <= c_S_HOLD;
                    end else if (w_fifo_next_empty) begin
                        r_state <= c_S_IDLE;
                    end
                end
                c_S_IDLE: begin
                    if (!w_drain_ok) begin
                        r_state <= c_S_HOLD;
                    end else if (w_push) begin
                        r_state <= c_S_DRAIN;
                    end
                end
                default: r_state <= c_S_HOLD;
            endcase
        end
    end

    // A write landing on the animate tick counts toward the closing frame and
    // also seeds the new frame's count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_write_count  <= '0;
            r_frame_writes <= '0;
        end else if (i_animate) begin
            r_frame_writes <= sat_add1(r_write_count, w_pop);
            r_write_count  <= {{(c_FRAME_W-1){1'b0}}, w_pop};
        end else begin
            r_write_count  <= sat_add1(r_write_count, w_pop);
        end
    end

endmodule
`default_nettype wire
